// File: rtl/paddle_ctrl.sv
// paddle_ctrl: two raw buttons -> clamped, centre-referenced paddle row, plus a registered draw strobe.
// Optional: define PADDLE_DEBOUNCE_EN to build the per-button debounce counters.
module paddle_ctrl #(
  parameter int HMAX           = 800,
  parameter int VMAX           = 525,
  parameter int HEIGHT         = 30,
  parameter int PIXEL_SIZE     = 16,
  parameter int PADDLE_H_POS   = 5,
  parameter int PADDLE_HALF    = 3,
  parameter int POS_INIT       = 15,
  parameter int POS_MIN        = 4,
  parameter int POS_MAX        = 27,
  parameter int MOVE_SPEED     = 1250000,
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic                      i_Clk,
  input  logic                      i_Reset,
  input  logic [$clog2(HMAX)-1:0]   i_H_count,
  input  logic [$clog2(VMAX)-1:0]   i_V_count,
  input  logic                      i_Up,
  input  logic                      i_Down,
  input  logic                      i_Enable,
  output logic [$clog2(HEIGHT)-1:0] o_Paddle_Pos,
  output logic                      o_Draw_Paddle
);

  localparam int PW = $clog2(HEIGHT);
  localparam int MW = $clog2(MOVE_SPEED + 1);
  localparam int DW = $clog2(HMAX) + 1;

  localparam logic [PW-1:0] POS_INIT_V = PW'(POS_INIT);
  localparam logic [PW-1:0] POS_MIN_V  = PW'(POS_MIN);
  localparam logic [PW-1:0] POS_MAX_V  = PW'(POS_MAX);
  localparam logic [MW-1:0] MOVE_LAST  = MW'(MOVE_SPEED - 1);
  localparam logic [DW-1:0] H_LO       = DW'((PADDLE_H_POS - 1) * PIXEL_SIZE);
  localparam logic [DW-1:0] H_HI       = DW'(PADDLE_H_POS * PIXEL_SIZE);

  typedef enum logic [1:0] {IDLE, STEP, HOLD} state_t;

  state_t        state;
  logic [MW-1:0] move_cnt;
  logic [PW-1:0] pos;
  logic [PW-1:0] next_pos;
  logic          up_meta, up_sync, dn_meta, dn_sync;
  logic          up_db, dn_db;
  logic          up_req, dn_req, any_req;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      up_meta <= 1'b0;
      up_sync <= 1'b0;
      dn_meta <= 1'b0;
      dn_sync <= 1'b0;
    end else begin
      up_meta <= i_Up;
      up_sync <= up_meta;
      dn_meta <= i_Down;
      dn_sync <= dn_meta;
    end
  end

`ifdef PADDLE_DEBOUNCE_EN
  localparam int DBW = $clog2(DEBOUNCE_LIMIT + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_LIMIT - 1);

  logic [DBW-1:0] up_cnt, dn_cnt;

  // A change is accepted only after DEBOUNCE_LIMIT consecutive disagreeing cycles.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      up_cnt <= '0;
      dn_cnt <= '0;
      up_db  <= 1'b0;
      dn_db  <= 1'b0;
    end else begin
      if (up_sync == up_db) begin
        up_cnt <= '0;
      end else if (up_cnt == DB_LAST) begin
        up_db  <= up_sync;
        up_cnt <= '0;
      end else begin
        up_cnt <= up_cnt + DBW'(1);
      end

      if (dn_sync == dn_db) begin
        dn_cnt <= '0;
      end else if (dn_cnt == DB_LAST) begin
        dn_db  <= dn_sync;
        dn_cnt <= '0;
      end else begin
        dn_cnt <= dn_cnt + DBW'(1);
      end
    end
  end
`else
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE_LIMIT > 0);
  assign up_db = up_sync;
  assign dn_db = dn_sync;
`endif

  assign up_req  = up_db & ~dn_db;
  assign dn_req  = dn_db & ~up_db;
  assign any_req = up_req | dn_req;

  always_comb begin
    next_pos = pos;
    if (dn_req && (pos < POS_MAX_V)) begin
      next_pos = pos + PW'(1);
    end else if (up_req && (pos > POS_MIN_V)) begin
      next_pos = pos - PW'(1);
    end
  end

  // The position is loaded on the edge that enters STEP, so the move is visible
  // one cycle after the debounced request and exactly MOVE_SPEED+1 cycles apart.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state    <= IDLE;
      move_cnt <= '0;
      pos      <= POS_INIT_V;
    end else begin
      case (state)
        IDLE: begin
          if (any_req && i_Enable) begin
            state <= STEP;
            pos   <= next_pos;
          end
        end
        STEP: begin
          state    <= HOLD;
          move_cnt <= '0;
        end
        HOLD: begin
          if (!any_req || !i_Enable) begin
            state <= IDLE;
          end else if (move_cnt == MOVE_LAST) begin
            state <= STEP;
            pos   <= next_pos;
          end else begin
            move_cnt <= move_cnt + MW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [DW-1:0] h_ext, v_ext, pos_ext, v_lo, v_hi;

  assign h_ext   = DW'(i_H_count);
  assign v_ext   = DW'(i_V_count);
  assign pos_ext = DW'(pos);
  assign v_lo    = (pos_ext - DW'(PADDLE_HALF + 1)) * DW'(PIXEL_SIZE);
  assign v_hi    = (pos_ext + DW'(PADDLE_HALF)) * DW'(PIXEL_SIZE);

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_Draw_Paddle <= 1'b0;
    end else begin
      o_Draw_Paddle <= (h_ext > H_LO) && (h_ext < H_HI) &&
                       (v_ext > v_lo) && (v_ext < v_hi);
    end
  end

  assign o_Paddle_Pos = pos;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Self-checking bench for paddle_ctrl: directed vectors plus random stimulus against a behavioural model.
// Expectations follow PADDLE_DEBOUNCE_EN when it is defined for the build.
module tb_paddle_ctrl;

  localparam int HMAX           = 800;
  localparam int VMAX           = 525;
  localparam int HEIGHT         = 30;
  localparam int PIXEL_SIZE     = 16;
  localparam int PADDLE_H_POS   = 5;
  localparam int PADDLE_HALF    = 3;
  localparam int POS_INIT       = 15;
  localparam int POS_MIN        = 4;
  localparam int POS_MAX        = 27;
  localparam int MOVE_SPEED     = 8;
  localparam int DEBOUNCE_LIMIT = 4;

`ifdef PADDLE_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif
  localparam int LAT      = DB_EN ? DEBOUNCE_LIMIT + 3 : 3;
  localparam int INTERVAL = MOVE_SPEED + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  h_cnt = '0;
  logic [9:0]  v_cnt = '0;
  logic        up_in = 1'b0;
  logic        dn_in = 1'b0;
  logic        en_in = 1'b1;
  logic [4:0]  dut_pos;
  logic        dut_draw;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  paddle_ctrl #(
    .HMAX(HMAX), .VMAX(VMAX), .HEIGHT(HEIGHT), .PIXEL_SIZE(PIXEL_SIZE),
    .PADDLE_H_POS(PADDLE_H_POS), .PADDLE_HALF(PADDLE_HALF), .POS_INIT(POS_INIT),
    .POS_MIN(POS_MIN), .POS_MAX(POS_MAX), .MOVE_SPEED(MOVE_SPEED),
    .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
  ) dut (
    .i_Clk(clk), .i_Reset(rst), .i_H_count(h_cnt), .i_V_count(v_cnt),
    .i_Up(up_in), .i_Down(dn_in), .i_Enable(en_in),
    .o_Paddle_Pos(dut_pos), .o_Draw_Paddle(dut_draw)
  );

  // Behavioural model: raw -> 2-cycle delay -> accept after LIMIT stable disagreeing samples,
  // then steps on request onset and every INTERVAL cycles while the request persists.
  int m_pos;
  bit m_draw;
  bit m_up_meta, m_up_sync, m_dn_meta, m_dn_sync, m_up_db, m_dn_db;
  bit up_hist[DEBOUNCE_LIMIT];
  bit dn_hist[DEBOUNCE_LIMIT];
  bit m_busy;
  int m_since;

  function automatic bit draw_rule(input int pos, input int h, input int v);
    return (h > (PADDLE_H_POS - 1) * PIXEL_SIZE) && (h < PADDLE_H_POS * PIXEL_SIZE) &&
           (v > (pos - PADDLE_HALF - 1) * PIXEL_SIZE) && (v < (pos + PADDLE_HALF) * PIXEL_SIZE);
  endfunction

  task automatic modelReset();
    m_pos = POS_INIT;
    m_draw = 1'b0;
    m_up_meta = 0; m_up_sync = 0; m_dn_meta = 0; m_dn_sync = 0;
    m_up_db = 0; m_dn_db = 0;
    for (int i = 0; i < DEBOUNCE_LIMIT; i++) begin
      up_hist[i] = 0;
      dn_hist[i] = 0;
    end
    m_busy = 0;
    m_since = 0;
  endtask

  task automatic modelEdge(input bit up, input bit dn, input bit en, input int h, input int v);
    bit up_req, dn_req, active, do_step, up_next, dn_next;
    up_req  = m_up_db && !m_dn_db;
    dn_req  = m_dn_db && !m_up_db;
    active  = (up_req || dn_req) && en;
    do_step = 0;
    m_draw  = draw_rule(m_pos, h, v);
    if (!m_busy) begin
      if (active) begin
        do_step = 1;
        m_busy = 1;
        m_since = 0;
      end
    end else begin
      m_since++;
      if (m_since != 1) begin
        if (!active) m_busy = 0;
        else if (m_since == INTERVAL) begin
          do_step = 1;
          m_since = 0;
        end
      end
    end
    if (do_step) begin
      if (dn_req) m_pos = (m_pos + 1 > POS_MAX) ? POS_MAX : m_pos + 1;
      else        m_pos = (m_pos - 1 < POS_MIN) ? POS_MIN : m_pos - 1;
    end
    for (int i = DEBOUNCE_LIMIT - 1; i > 0; i--) begin
      up_hist[i] = up_hist[i-1];
      dn_hist[i] = dn_hist[i-1];
    end
    up_hist[0] = m_up_sync;
    dn_hist[0] = m_dn_sync;
    up_next = !m_up_db;
    dn_next = !m_dn_db;
    for (int i = 0; i < DEBOUNCE_LIMIT; i++) begin
      if (up_hist[i] == m_up_db) up_next = m_up_db;
      if (dn_hist[i] == m_dn_db) dn_next = m_dn_db;
    end
    m_up_sync = m_up_meta; m_up_meta = up;
    m_dn_sync = m_dn_meta; m_dn_meta = dn;
    m_up_db = DB_EN ? up_next : m_up_sync;
    m_dn_db = DB_EN ? dn_next : m_dn_sync;
  endtask

  // Called at a falling edge: drive inputs, advance the model, return at the next falling edge.
  task automatic applyStimulus(input bit up, input bit dn, input bit en, input int h, input int v);
    up_in = up;
    dn_in = dn;
    en_in = en;
    h_cnt = 10'(h);
    v_cnt = 10'(v);
    modelEdge(up, dn, en, h, v);
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit up, input bit dn, input bit en);
    for (int i = 0; i < n; i++) applyStimulus(up, dn, en, 0, 0);
  endtask

  task automatic checkOutput(input string name, input int exp_pos, input bit exp_draw);
    vectors++;
    if (int'(dut_pos) != exp_pos || dut_draw != exp_draw) begin
      miscompares++;
      $display("[TB] FAIL %s: got pos=%0d draw=%0d, expected pos=%0d draw=%0d",
               name, dut_pos, dut_draw, exp_pos, exp_draw);
    end
  endtask

  task automatic doReset();
    up_in = 0; dn_in = 0; en_in = 1; h_cnt = '0; v_cnt = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  typedef struct {
    int h;
    int v;
    bit exp_draw;
  } draw_vec_t;

  draw_vec_t draw_tbl[9];

  initial begin
    draw_tbl[0] = '{70, 200, 1'b1};
    draw_tbl[1] = '{64, 200, 1'b0};
    draw_tbl[2] = '{65, 200, 1'b1};
    draw_tbl[3] = '{79, 200, 1'b1};
    draw_tbl[4] = '{80, 200, 1'b0};
    draw_tbl[5] = '{70, 176, 1'b0};
    draw_tbl[6] = '{70, 177, 1'b1};
    draw_tbl[7] = '{70, 287, 1'b1};
    draw_tbl[8] = '{70, 288, 1'b0};

    modelReset();
    @(negedge clk);
    doReset();
    checkOutput("reset_state", POS_INIT, 1'b0);

    // Asynchronous reset in the middle of HOLD, with the draw strobe active.
    for (int i = 0; i < LAT + 3; i++) applyStimulus(0, 1, 1, 70, 200);
    checkOutput("hold_before_reset", 16, 1'b1);
    #2 rst = 1'b1;
    #1 checkOutput("async_reset", POS_INIT, 1'b0);
    up_in = 0; dn_in = 0; h_cnt = '0; v_cnt = '0;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    run(20, 0, 0, 1);
    checkOutput("post_reset_idle", POS_INIT, 1'b0);

    // Held Down: first step after LAT cycles, then every INTERVAL cycles.
    doReset();
    run(LAT - 1, 0, 1, 1);
    checkOutput("down_before_first", 15, 1'b0);
    run(1, 0, 1, 1);
    checkOutput("down_first_step", 16, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      run(INTERVAL - 1, 0, 1, 1);
      checkOutput("down_interval_early", 15 + k, 1'b0);
      run(1, 0, 1, 1);
      checkOutput("down_interval_step", 16 + k, 1'b0);
    end

    // Clamp at the top and bottom limits.
    doReset();
    run(LAT + 9 * INTERVAL, 1, 0, 1);
    checkOutput("up_near_min", 5, 1'b0);
    run(INTERVAL, 1, 0, 1);
    checkOutput("up_at_min", POS_MIN, 1'b0);
    run(3 * INTERVAL, 1, 0, 1);
    checkOutput("up_clamped", POS_MIN, 1'b0);
    doReset();
    run(LAT + 10 * INTERVAL, 0, 1, 1);
    checkOutput("down_near_max", 26, 1'b0);
    run(INTERVAL, 0, 1, 1);
    checkOutput("down_at_max", POS_MAX, 1'b0);
    run(3 * INTERVAL, 0, 1, 1);
    checkOutput("down_clamped", POS_MAX, 1'b0);

    // Short glitch and conflicting buttons.
    doReset();
    run(3, 1, 0, 1);
    run(20, 0, 0, 1);
    checkOutput("glitch_3cyc", DB_EN ? 15 : 14, 1'b0);
    doReset();
    run(LAT + 2, 1, 1, 1);
    checkOutput("both_pressed_a", 15, 1'b0);
    run(3 * INTERVAL, 1, 1, 1);
    checkOutput("both_pressed_b", 15, 1'b0);

    // Enable drop freezes; raising it steps on the very next cycle.
    doReset();
    run(LAT, 0, 1, 1);
    checkOutput("enable_first_step", 16, 1'b0);
    run(2, 0, 1, 1);
    run(30, 0, 1, 0);
    checkOutput("enable_frozen", 16, 1'b0);
    run(1, 0, 1, 1);
    checkOutput("enable_resume", 17, 1'b0);

    // Draw window boundaries at pos 15.
    doReset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 0, 1, draw_tbl[i].h, draw_tbl[i].v);
      checkOutput($sformatf("draw_h%0d_v%0d", draw_tbl[i].h, draw_tbl[i].v), 15, draw_tbl[i].exp_draw);
    end

    // Random button segments checked every cycle against the model.
    doReset();
    for (int seg = 0; seg < 120; seg++) begin
      bit up_r, dn_r, en_r;
      int len;
      up_r = 1'($urandom_range(0, 1));
      dn_r = 1'($urandom_range(0, 1));
      en_r = ($urandom_range(0, 7) != 0);
      len  = $urandom_range(1, 25);
      for (int c = 0; c < len; c++) begin
        int h, v;
        h = ($urandom_range(0, 1) == 1) ? $urandom_range(60, 85) : $urandom_range(0, HMAX - 1);
        v = $urandom_range(0, VMAX - 1);
        applyStimulus(up_r, dn_r, en_r, h, v);
        checkOutput("random", m_pos, m_draw);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
